// File: rtl/seq_addsub_pkg.sv
// Shared types and elaboration helpers for the serial adder/subtractor.
// The full_adder cell lives here so every slice builds its ripple chain from one definition.
package seq_addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        int unsigned n;      // number of DIGIT-bit slices
        int unsigned cnt_w;  // slice counter width
    } geom_t;

    typedef struct packed {
        logic s;
        logic co;
    } fa_t;

    function automatic geom_t slice_geom(input int unsigned width, input int unsigned digit);
        geom_t g;
        g.n     = width / digit;
        g.cnt_w = (g.n > 1) ? $clog2(g.n) : 1;
        return g;
    endfunction

    function automatic bit geom_ok(input int unsigned width, input int unsigned digit);
        return (digit >= 1) && (digit <= width) && ((width % digit) == 0);
    endfunction

    function automatic fa_t full_adder(input logic x, input logic y, input logic ci);
        fa_t r;
        r.s  = x ^ y ^ ci;
        r.co = (x & y) | (ci & (x ^ y));
        return r;
    endfunction

endpackage

// File: rtl/addsub_digit.sv
// Combinational DIGIT-bit ripple slice built from full_adder cells.
// c_top is the carry entering the slice's top bit, used for overflow detection.
module addsub_digit
    import seq_addsub_pkg::*;
#(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             ci,
    output logic [DIGIT-1:0] s,
    output logic             co,
    output logic             c_top
);

    always_comb begin
        logic c;
        fa_t  fa;
        // NOTE: every output gets a default before the loop so no path leaves one unassigned (no latch).
        s     = '0;
        c_top = ci;
        c     = ci;
        // NOTE: blocking '=' here so each bit uses the carry produced by the bit just below it.
        for (int i = 0; i < DIGIT; i++) begin
            c_top = c;
            fa    = full_adder(x[i], y[i], c);
            s[i]  = fa.s;
            c     = fa.co;
        end
        co = c;
    end

endmodule

// File: rtl/seq_addsub.sv
// Multi-cycle WIDTH-bit adder/subtractor, one DIGIT-bit slice per clock, LSB slice first.
// Define SEQ_ADDSUB_OVF_EN to build the two's-complement overflow output; otherwise ovf is 0.
module seq_addsub
    import seq_addsub_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam geom_t GEOM  = slice_geom(WIDTH, DIGIT);
    localparam int    N     = int'(GEOM.n);
    localparam int    CNT_W = int'(GEOM.cnt_w);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N - 1);

    if (!geom_ok(WIDTH, DIGIT)) begin : g_bad_geometry
        $error("seq_addsub: WIDTH must be a positive multiple of DIGIT");
    end

    state_t           state, state_nxt;
    logic [WIDTH-1:0] op_a, op_b, acc, acc_nxt;
    logic             carry;
    logic [CNT_W-1:0] idx;
    logic [DIGIT-1:0] slice_s;
    logic             slice_co, slice_ci_top;
    logic             last_slice;

    // Operands shift right each RUN cycle, so slice idx is always in the low DIGIT bits.
    addsub_digit #(.DIGIT(DIGIT)) u_digit (
        .x     (op_a[DIGIT-1:0]),
        .y     (op_b[DIGIT-1:0]),
        .ci    (carry),
        .s     (slice_s),
        .co    (slice_co),
        .c_top (slice_ci_top)
    );

    assign acc_nxt    = WIDTH'({slice_s, acc} >> DIGIT);
    assign last_slice = (idx == LAST_IDX);
    assign busy       = (state != IDLE);
    assign done       = (state == DONE);

    always_ff @(posedge clk) begin
        // NOTE: non-blocking '<=' for all registered state so every flop samples pre-edge values.
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last_slice) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: working registers are cleared too, so an aborted operation leaves no residue.
            op_a  <= '0;
            op_b  <= '0;
            acc   <= '0;
            carry <= 1'b0;
            idx   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        op_a  <= a;
                        op_b  <= b ^ {WIDTH{sub}};
                        carry <= cin;
                        idx   <= '0;
                        acc   <= '0;
                    end
                end
                RUN: begin
                    op_a  <= op_a >> DIGIT;
                    op_b  <= op_b >> DIGIT;
                    acc   <= acc_nxt;
                    carry <= slice_co;
                    idx   <= idx + CNT_W'(1);
                    if (last_slice) begin
                        sum  <= acc_nxt;
                        cout <= slice_co;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef SEQ_ADDSUB_OVF_EN
    always_ff @(posedge clk) begin
        if (rst)
            ovf <= 1'b0;
        else if (state == RUN && last_slice)
            ovf <= slice_ci_top ^ slice_co;
    end
`else
    logic unused_ci_top;
    assign unused_ci_top = slice_ci_top;
    assign ovf           = 1'b0;
`endif

endmodule

// File: tb/tb_seq_addsub.sv
// Self-checking bench for seq_addsub: directed vector table, corner sequences, random ops vs a model.
// Three instances cover DIGIT=4 (main), DIGIT=16 (N=1) and DIGIT=1 (N=16).
module tb_seq_addsub;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        sub;
        logic        cin;
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
    } vec_t;

    typedef struct packed {
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
    } res_t;

`ifdef SEQ_ADDSUB_OVF_EN
    localparam bit OVF_ON = 1'b1;
`else
    localparam bit OVF_ON = 1'b0;
`endif

    localparam int LAT [3] = '{5, 2, 17};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sub = 1'b0;
    logic        cin = 1'b0;
    logic [15:0] a   = '0;
    logic [15:0] b   = '0;
    logic [2:0]  start_v = '0;
    logic [2:0]  busy_v, done_v, cout_v, ovf_v;
    logic [15:0] sum_v [3];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    seq_addsub #(.WIDTH(16), .DIGIT(4)) dut (
        .clk(clk), .rst(rst), .start(start_v[0]), .sub(sub), .a(a), .b(b), .cin(cin),
        .busy(busy_v[0]), .done(done_v[0]), .sum(sum_v[0]), .cout(cout_v[0]), .ovf(ovf_v[0])
    );

    seq_addsub #(.WIDTH(16), .DIGIT(16)) dut_wide (
        .clk(clk), .rst(rst), .start(start_v[1]), .sub(sub), .a(a), .b(b), .cin(cin),
        .busy(busy_v[1]), .done(done_v[1]), .sum(sum_v[1]), .cout(cout_v[1]), .ovf(ovf_v[1])
    );

    seq_addsub #(.WIDTH(16), .DIGIT(1)) dut_bit (
        .clk(clk), .rst(rst), .start(start_v[2]), .sub(sub), .a(a), .b(b), .cin(cin),
        .busy(busy_v[2]), .done(done_v[2]), .sum(sum_v[2]), .cout(cout_v[2]), .ovf(ovf_v[2])
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the full 16-bit word.
    function automatic res_t model(input logic [15:0] ma, input logic [15:0] mb,
                                   input logic msub, input logic mcin);
        logic [15:0] bb;
        logic [16:0] full;
        res_t        r;
        bb     = msub ? ~mb : mb;
        full   = {1'b0, ma} + {1'b0, bb} + 17'(mcin);
        r.sum  = full[15:0];
        r.cout = full[16];
        r.ovf  = OVF_ON && (ma[15] == bb[15]) && (full[15] != ma[15]);
        return r;
    endfunction

    // Start one operation on instance sel and return edges from accept to done (accept counts as 1).
    task automatic run_op(input int sel, input logic [15:0] ta, input logic [15:0] tb_v,
                          input logic ts, input logic tc, output int edges, output res_t r);
        @(negedge clk);
        a = ta; b = tb_v; sub = ts; cin = tc;
        start_v[sel] = 1'b1;
        @(negedge clk);
        start_v[sel] = 1'b0;
        a = 16'($urandom); b = 16'($urandom); sub = 1'($urandom); cin = 1'($urandom);
        check($sformatf("busy after accept [%0d]", sel), 32'(busy_v[sel]), 32'd1);
        edges = 1;
        while (!done_v[sel] && edges < 40) begin
            @(negedge clk);
            edges++;
        end
        r = '{sum: sum_v[sel], cout: cout_v[sel], ovf: ovf_v[sel]};
        check($sformatf("busy with done [%0d]", sel), 32'(busy_v[sel]), 32'(done_v[sel]));
        @(negedge clk);
        check($sformatf("done pulse width [%0d]", sel), 32'(done_v[sel]), 32'd0);
        check($sformatf("idle after done [%0d]", sel), 32'(busy_v[sel]), 32'd0);
    endtask

    initial begin
        vec_t vecs [7];
        res_t got, exp;
        int   edges, dones;

        vecs[0] = '{16'h1234, 16'h0FFF, 1'b0, 1'b0, 16'h2233, 1'b0, 1'b0};
        vecs[1] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, OVF_ON};
        vecs[3] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[4] = '{16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, OVF_ON};
        vecs[5] = '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0001, 1'b0, 1'b0};
        vecs[6] = '{16'h1234, 16'h1234, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0};

        repeat (3) @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            check($sformatf("reset busy [%0d]", s), 32'(busy_v[s]), 32'd0);
            check($sformatf("reset done [%0d]", s), 32'(done_v[s]), 32'd0);
            check($sformatf("reset result [%0d]", s), {13'd0, sum_v[s], cout_v[s], ovf_v[s]}, 32'd0);
        end
        rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            run_op(0, vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].cin, edges, got);
            check($sformatf("vec%0d latency", i), edges, 32'd5);
            check($sformatf("vec%0d sum", i), 32'(got.sum), 32'(vecs[i].sum));
            check($sformatf("vec%0d cout", i), 32'(got.cout), 32'(vecs[i].cout));
            check($sformatf("vec%0d ovf", i), 32'(got.ovf), 32'(vecs[i].ovf));
        end

        // Result holds through idle cycles while inputs wander.
        run_op(0, 16'h1234, 16'h0FFF, 1'b0, 1'b0, edges, got);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            a = 16'($urandom); b = 16'($urandom);
            check($sformatf("hold cycle %0d", k), {13'd0, sum_v[0], cout_v[0], ovf_v[0]},
                  {13'd0, 16'h2233, 1'b0, 1'b0});
        end
        run_op(0, 16'hFFFF, 16'h0001, 1'b0, 1'b0, edges, got);
        repeat (10) @(negedge clk);
        check("hold ffff+1", {13'd0, sum_v[0], cout_v[0], ovf_v[0]}, {13'd0, 16'h0000, 1'b1, 1'b0});

        // start pulsed in RUN and again in DONE must be ignored.
        @(negedge clk);
        a = 16'h1234; b = 16'h0FFF; sub = 1'b0; cin = 1'b0; start_v[0] = 1'b1;
        dones = 0;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            start_v[0] = (k == 2 || k == 5);
            if (k == 2) begin a = 16'hAAAA; b = 16'h5555; end
            if (done_v[0]) begin
                dones++;
                got.sum = sum_v[0];
            end
        end
        check("ignored start done count", dones, 32'd1);
        check("ignored start sum", 32'(got.sum), 32'h2233);

        // Reset on the second RUN cycle aborts the operation.
        @(negedge clk);
        a = 16'hFFFF; b = 16'h0001; start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort busy", 32'(busy_v[0]), 32'd0);
        check("abort result", {13'd0, sum_v[0], cout_v[0], ovf_v[0]}, 32'd0);
        dones = 0;
        repeat (10) begin
            @(negedge clk);
            if (done_v[0]) dones++;
        end
        check("abort no done", dones, 32'd0);
        run_op(0, 16'h7FFF, 16'h0001, 1'b0, 1'b0, edges, got);
        check("after abort latency", edges, 32'd5);
        check("after abort result", {13'd0, got}, {13'd0, 16'h8000, 1'b0, OVF_ON});

        // Reset during the done cycle clears the just-loaded result.
        @(negedge clk);
        a = 16'h1234; b = 16'h0FFF; start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (4) @(negedge clk);
        check("done before rst", 32'(done_v[0]), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst in done", {13'd0, sum_v[0], cout_v[0], busy_v[0]}, 32'd0);

        // start together with rst is dropped.
        @(negedge clk);
        rst = 1'b1; start_v[0] = 1'b1;
        @(negedge clk);
        rst = 1'b0; start_v[0] = 1'b0;
        check("start with rst", 32'(busy_v[0]), 32'd0);
        @(negedge clk);
        check("start with rst later", 32'(busy_v[0]), 32'd0);

        // N=1 and N=16 instances.
        for (int s = 1; s < 3; s++) begin
            run_op(s, 16'h1234, 16'h0FFF, 1'b0, 1'b0, edges, got);
            check($sformatf("geom%0d latency", s), edges, 32'(LAT[s]));
            check($sformatf("geom%0d sum", s), 32'(got.sum), 32'h2233);
        end

        // Random operations on all instances against the model.
        for (int i = 0; i < 60; i++) begin
            int          s;
            logic [15:0] ra, rb;
            logic        rs, rc;
            s  = (i < 40) ? 0 : ((i < 50) ? 1 : 2);
            ra = 16'($urandom); rb = 16'($urandom);
            rs = 1'($urandom);  rc = 1'($urandom);
            if (i % 8 == 0) rb = ra;
            exp = model(ra, rb, rs, rc);
            run_op(s, ra, rb, rs, rc, edges, got);
            check($sformatf("rand%0d latency", i), edges, 32'(LAT[s]));
            check($sformatf("rand%0d %h%s%h+%0d", i, ra, rs ? "-" : "+", rb, rc),
                  {13'd0, got}, {13'd0, exp});
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
